// File: rtl/mac_load_seq.sv
// mac_load_seq: per-tile weight/input load sequencer feeding the MAC-array control pipeline register.
module mac_load_seq #(
  parameter int CALC_CYCLES = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] NTILE,
  input  logic [4:0] SHAMT,
  input  logic       STALL,
  input  logic       ABORT,
  output logic       RD_EN,
  output logic [6:0] RD_ADDR,
  output logic       START_CALC0,
  output logic       ILoad0,
  output logic       WLoad0,
  output logic [4:0] shamt0,
  output logic [1:0] ICOL0,
  output logic [1:0] WROW0,
  output logic [3:0] ODST0,
  output logic       BUSY,
  output logic       DONE
);
  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_ILOAD, S_CALC, S_WAIT, S_DONE} state_t;
  localparam logic [3:0] WLAST = 4'(CALC_CYCLES - 1);
  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] tile_q, tile_d, wcnt_q, wcnt_d, ntile_q, ntile_d;
  logic [4:0] shamt_q, shamt_d;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tile_q  <= '0;
      wcnt_q  <= '0;
      ntile_q <= '0;
      shamt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tile_q  <= tile_d;
      wcnt_q  <= wcnt_d;
      ntile_q <= ntile_d;
      shamt_q <= shamt_d;
    end
  // tile/idx are cleared on every return to IDLE so address outputs read 0 there
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tile_d  = tile_q;
    wcnt_d  = wcnt_q;
    ntile_d = ntile_q;
    shamt_d = shamt_q;
    if (state_q == S_IDLE) begin
      if (START) begin
        ntile_d = NTILE;
        shamt_d = SHAMT;
        tile_d  = '0;
        idx_d   = '0;
        state_d = S_WLOAD;
      end
    end else if (ABORT) begin
      state_d = S_IDLE;
      tile_d  = '0;
      idx_d   = '0;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        S_WLOAD, S_ILOAD: if (!STALL) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = (state_q == S_WLOAD) ? S_ILOAD : S_CALC;
        end
        S_CALC: begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
        S_WAIT: if (wcnt_q == WLAST) begin
          wcnt_d  = '0;
          state_d = (tile_q == ntile_q) ? S_DONE : S_WLOAD;
          tile_d  = (tile_q == ntile_q) ? tile_q : tile_q + 4'd1;
        end else wcnt_d = wcnt_q + 4'd1;
        default: begin
          state_d = S_IDLE;
          tile_d  = '0;
          idx_d   = '0;
        end
      endcase
    end
  end
  assign WLoad0      = (state_q == S_WLOAD) & ~STALL;
  assign ILoad0      = (state_q == S_ILOAD) & ~STALL;
  assign RD_EN       = WLoad0 | ILoad0;
  assign RD_ADDR     = {state_q == S_ILOAD, tile_q, idx_q};
  assign START_CALC0 = state_q == S_CALC;
  assign shamt0      = (state_q == S_IDLE) ? 5'd0 : shamt_q;
  assign ICOL0       = (state_q == S_ILOAD) ? idx_q : 2'd0;
  assign WROW0       = (state_q == S_WLOAD) ? idx_q : 2'd0;
  assign ODST0       = tile_q;
  assign BUSY        = state_q inside {S_WLOAD, S_ILOAD, S_CALC, S_WAIT};
  assign DONE        = state_q == S_DONE;
endmodule

// File: tb/tb_mac_load_seq.sv
// tb_mac_load_seq: directed checks of tile sequencing, stall, abort and reset behaviour.
module tb_mac_load_seq;
  logic       CLK, RST, START, STALL, ABORT;
  logic [3:0] NTILE;
  logic [4:0] SHAMT;
  logic       RD_EN, START_CALC0, ILoad0, WLoad0, BUSY, DONE;
  logic [6:0] RD_ADDR;
  logic [4:0] shamt0;
  logic [1:0] ICOL0, WROW0;
  logic [3:0] ODST0;
  logic [25:0] outs;
  int total, passed;

  mac_load_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .NTILE(NTILE), .SHAMT(SHAMT),
    .STALL(STALL), .ABORT(ABORT), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
    .START_CALC0(START_CALC0), .ILoad0(ILoad0), .WLoad0(WLoad0),
    .shamt0(shamt0), .ICOL0(ICOL0), .WROW0(WROW0), .ODST0(ODST0),
    .BUSY(BUSY), .DONE(DONE)
  );

  assign outs = {RD_EN, RD_ADDR, START_CALC0, ILoad0, WLoad0, shamt0, ICOL0, WROW0, ODST0, BUSY, DONE};

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected output vector for cycle c (1 = first cycle after the START edge), 16-cycle tiles, no stalls.
  function automatic logic [25:0] exp_vec(int c, int nt, logic [4:0] sh);
    int p, t;
    logic w, i, k, b, d;
    logic [1:0] wr, ic;
    logic [6:0] a;
    d = (c == 1 + (nt + 1) * 16);
    t = d ? nt : (c - 1) / 16;
    p = d ? 0 : (c - 1) % 16 + 1;
    w = !d && p <= 4;
    i = !d && p >= 5 && p <= 8;
    k = !d && p == 9;
    b = !d;
    wr = w ? 2'(p - 1) : 2'd0;
    ic = i ? 2'(p - 5) : 2'd0;
    a = {i, 4'(t), w ? wr : ic};
    return {w | i, a, k, i, w, sh, ic, wr, 4'(t), b, d};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_op(input logic [3:0] nt, input logic [4:0] sh);
    NTILE = nt;
    SHAMT = sh;
    START = 1;
    @(posedge CLK);
    #1;
    START = 0;
  endtask

  task automatic test_reset();
    RST = 1; START = 0; STALL = 0; ABORT = 0; NTILE = 0; SHAMT = 0;
    @(posedge CLK);
    @(negedge CLK);
    total++;
    if (outs !== 26'd0) $display("FAIL reset_outs: got %h want %h", outs, 26'd0);
    else passed++;
    RST = 0;
    ABORT = 1;
    tick();
    ABORT = 0;
    @(negedge CLK);
    total++;
    if (outs !== 26'd0) $display("FAIL abort_in_idle: got %h want %h", outs, 26'd0);
    else passed++;
  endtask

  task automatic test_single();
    start_op(4'd0, 5'd5);
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) tick();
      @(negedge CLK);
      total++;
      if (outs !== (c == 18 ? 26'd0 : exp_vec(c, 0, 5'd5)))
        $display("FAIL single cyc%0d: got %h want %h", c, outs, (c == 18 ? 26'd0 : exp_vec(c, 0, 5'd5)));
      else passed++;
    end
  endtask

  task automatic test_three_tiles();
    start_op(4'd2, 5'd3);
    for (int c = 1; c <= 49; c++) begin
      if (c > 1) tick();
      @(negedge CLK);
      total++;
      if (outs !== exp_vec(c, 2, 5'd3))
        $display("FAIL three cyc%0d: got %h want %h", c, outs, exp_vec(c, 2, 5'd3));
      else passed++;
    end
    @(negedge CLK);
    total++;
    if (RD_ADDR !== 7'h00 || ODST0 !== 4'd0) $display("FAIL three_idle: got addr %h odst %0d want 0 0", RD_ADDR, ODST0);
    else passed++;
  endtask

  task automatic test_stall();
    start_op(4'd0, 5'd0);
    for (int c = 1; c <= 19; c++) begin
      if (c > 1) tick();
      STALL = (c == 2 || c == 3);
      @(negedge CLK);
      if (c <= 4) begin
        total++;
        if ({WLoad0, RD_EN, WROW0} !== (c == 1 ? 4'b1100 : c == 4 ? 4'b1101 : 4'b0001))
          $display("FAIL stall cyc%0d: got wl/rd/wrow %b want %b", c, {WLoad0, RD_EN, WROW0},
                   (c == 1 ? 4'b1100 : c == 4 ? 4'b1101 : 4'b0001));
        else passed++;
      end
      if (c == 10 || c == 11) begin
        total++;
        if (START_CALC0 !== (c == 11)) $display("FAIL stall_calc cyc%0d: got %b want %b", c, START_CALC0, c == 11);
        else passed++;
      end
      if (c == 19) begin
        total++;
        if (DONE !== 1'b1) $display("FAIL stall_done cyc19: got %b want 1", DONE);
        else passed++;
      end
    end
    STALL = 0;
    tick();
  endtask

  task automatic test_abort();
    logic saw_done;
    start_op(4'd1, 5'd9);
    for (int c = 2; c <= 7; c++) tick();
    @(negedge CLK);
    total++;
    if ({ILoad0, ICOL0, RD_ADDR} !== {1'b1, 2'd2, 7'h42})
      $display("FAIL abort_pre: got %h want %h", {ILoad0, ICOL0, RD_ADDR}, {1'b1, 2'd2, 7'h42});
    else passed++;
    ABORT = 1;
    tick();
    ABORT = 0;
    @(negedge CLK);
    total++;
    if (outs !== 26'd0) $display("FAIL abort_idle: got %h want %h", outs, 26'd0);
    else passed++;
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      saw_done |= DONE;
    end
    total++;
    if (saw_done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", saw_done);
    else passed++;
    ABORT = 1;
    start_op(4'd0, 5'd1);
    ABORT = 0;
    @(negedge CLK);
    total++;
    if (outs !== exp_vec(1, 0, 5'd1)) $display("FAIL abort_restart: got %h want %h", outs, exp_vec(1, 0, 5'd1));
    else passed++;
    for (int c = 2; c <= 17; c++) tick();
    @(negedge CLK);
    total++;
    if (DONE !== 1'b1) $display("FAIL abort_restart_done: got %b want 1", DONE);
    else passed++;
    tick();
  endtask

  task automatic test_start_in_done();
    start_op(4'd0, 5'd7);
    for (int c = 2; c <= 17; c++) tick();
    @(negedge CLK);
    total++;
    if (DONE !== 1'b1) $display("FAIL done_cycle: got %b want 1", DONE);
    else passed++;
    START = 1;
    tick();
    START = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      total++;
      if (outs !== 26'd0) $display("FAIL start_in_done %0d: got %h want %h", c, outs, 26'd0);
      else passed++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic saw_done;
    start_op(4'd0, 5'd4);
    for (int c = 2; c <= 12; c++) tick();
    @(negedge CLK);
    total++;
    if ({BUSY, START_CALC0, RD_EN} !== 3'b100) $display("FAIL wait_state: got %b want 100", {BUSY, START_CALC0, RD_EN});
    else passed++;
    #1 RST = 1;
    #1;
    total++;
    if (outs !== 26'd0) $display("FAIL async_reset: got %h want %h", outs, 26'd0);
    else passed++;
    @(negedge CLK);
    RST = 0;
    saw_done = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      saw_done |= DONE;
    end
    total++;
    if (saw_done !== 1'b0 || outs !== 26'd0) $display("FAIL async_no_done: got done %b outs %h want 0 0", saw_done, outs);
    else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_single();
    test_three_tiles();
    test_stall();
    test_abort();
    test_start_in_done();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mac_load_seq.md
# mac_load_seq

Control sequencer directly upstream of the MAC-array control pipeline register. For each output tile it generates the control word that the pipeline register delays by one cycle: 4 weight-row load beats, then 4 input-column load beats, a single START_CALC0 pulse tagged with the tile's output destination, and a fixed drain wait. It issues matching memory read strobes and addresses, absorbs memory back-pressure through STALL, and supports abort.

## Interface
- CALC_CYCLES, 7: drain cycles after the START_CALC0 pulse before the next tile begins; legal range 1..15.
- CLK  in  1  clock; all flops rise-edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  begin an operation; sampled only in IDLE.
- NTILE  in  4  number of tiles minus 1 (1..16 tiles); latched on START.
- SHAMT  in  5  output shift amount; latched on START.
- STALL  in  1  memory not ready; blocks the current load beat.
- ABORT  in  1  cancel the operation; highest priority after RST.
- RD_EN  out  1  memory read strobe for the current beat.
- RD_ADDR  out  7  {phase, tile[3:0], idx[1:0]}; phase 0 = weights, 1 = inputs.
- START_CALC0, ILoad0, WLoad0  out  1 each  control strobes to the pipeline register.
- shamt0  out  5  latched SHAMT, held for the whole operation.
- ICOL0, WROW0  out  2 each  input column / weight row of the current beat.
- ODST0  out  4  output destination; equals the current tile index.
- BUSY  out  1  high in WLOAD, ILOAD, CALC and WAIT.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: START=1 latches NTILE and SHAMT, clears tile and idx, and moves to WLOAD.
  - WLOAD: 4 beats, WROW0 = idx.
  - ILOAD: 4 beats, ICOL0 = idx.
  - CALC: exactly 1 cycle.
  - WAIT: CALC_CYCLES cycles.
  - After WAIT: if tile == NTILE, go to DONE; otherwise tile+1 and go to WLOAD.
  - DONE: 1 cycle, then IDLE.
- Beats:
  - A beat issues in a load state when STALL=0. At that edge idx increments, and after idx=3 it wraps to 0 with a state change.
  - With STALL=1, idx and state hold.
- Strobe gating: WLoad0 = (WLOAD & ~STALL), ILoad0 = (ILOAD & ~STALL), RD_EN = WLoad0 | ILoad0. This is the only combinational input-to-output path; all other outputs decode registered state.
- Addressing: RD_ADDR = {state==ILOAD, tile, idx}. WROW0/ICOL0 show idx in their own load state and 0 otherwise.
- START_CALC0 = 1 only in CALC. ODST0 = tile in every non-IDLE state and 0 in IDLE.
- STALL is ignored in CALC, WAIT and DONE.
- START is ignored outside IDLE, including during DONE.
- ABORT=1 at an edge in any non-IDLE state forces IDLE next cycle with no DONE pulse. ABORT in IDLE has no effect. If START and ABORT are both high in IDLE, START wins.
- Counters: idx is 2-bit; tile is 4-bit and never exceeds NTILE, so there is no overflow. The wait counter is 4-bit.

## Timing
- Reset (RST high, asynchronous):
  - State goes to IDLE; idx, tile, wait count and latched NTILE/SHAMT clear.
  - All outputs read 0: RD_EN, RD_ADDR, START_CALC0, ILoad0, WLoad0, shamt0, ICOL0, WROW0, ODST0, BUSY, DONE.
  - Reset asserted mid-operation discards the operation; release resumes in IDLE.
- Latency and tile length:
  - START sampled at edge 0 gives the first WLoad0 in cycle 1.
  - Unstalled tile length is 9 + CALC_CYCLES cycles; each stall cycle adds 1.
- Total latency, unstalled: DONE occurs at cycle 1 + (NTILE+1)·(9+CALC_CYCLES) after the START edge.
- Tile turnaround: the next tile's WLOAD directly follows the last WAIT cycle, with no bubble.

## Test plan
- Single tile (CALC_CYCLES=7): reset, then START with NTILE=0, SHAMT=5. Required:
  - Cycles 1–4: WLoad0=1, WROW0=0..3, RD_ADDR=0x00..0x03.
  - Cycles 5–8: ILoad0=1, ICOL0=0..3, RD_ADDR=0x40..0x43.
  - Cycle 9: START_CALC0=1, ODST0=0.
  - Cycles 10–16: BUSY=1, no strobes.
  - Cycle 17: DONE=1, BUSY=0.
  - shamt0=5 throughout.
- Three tiles: NTILE=2. Required: START_CALC0 at cycles 9, 25 and 41 with ODST0 0, 1, 2. Tile-2 weight beats use RD_ADDR=0x08..0x0B. DONE at cycle 49.
- Stall: STALL=1 during cycles 2–3 of tile 0. Required:
  - WLoad0=0 and RD_EN=0 in cycles 2–3, with WROW0 holding 1.
  - Beats resume in cycle 4.
  - START_CALC0 moves to cycle 11.
- Abort: ABORT=1 while in ILOAD with idx=2. Required: the next cycle is IDLE with every output 0 and no DONE. A fresh START then restarts at tile 0, WROW0=0.
- START in DONE: pulse START in the DONE cycle. Required: it is ignored; the block stays IDLE.
- Asynchronous reset in WAIT: assert RST between clock edges. Required: outputs go 0 immediately and DONE never asserts.
